stopwatch_core: RTL

Centisecond stopwatch that sits directly downstream of the programmable clock divider. It consumes the divider's 100 Hz square-wave output as a tick strobe, keeps a BCD mm:ss.cc count under start/stop/clear key control, and drives the divider's enable input. Its BCD outputs feed the seven-segment display driver.

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/stopwatch_core_bcd_digit.sv | 45 ++++
 rtl/stopwatch_core.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: types and constants shared by the stopwatch core and its
// BCD digit cells.
//   sw_state_e  - control state (IDLE / RUN / PAUSE)
//   DIGIT_MAX_* - roll-over values for decimal and base-6 digits
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_e;

    localparam logic [3:0] DIGIT_MAX_9 = 4'd9;
    localparam logic [3:0] DIGIT_MAX_5 = 4'd5;

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// bcd_digit: one BCD counter digit, 0..MAX, with synchronous clear.
// Ports:
//   clkin  - system clock
//   rst_n  - asynchronous active-low reset
//   clr    - synchronous clear to 0 (wins over inc)
//   inc    - increment enable (carry-in)
//   q      - current digit value
//   carry  - carry-out, high when incrementing from MAX
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX_9
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = (q_q == MAX) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc & (q_q == MAX);

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: centisecond stopwatch (BCD mm:ss.cc) counting rising
// edges of the 100 Hz divider output, controlled by start/stop and clear
// keys. Drives the divider enable.
// Optional feature macro: STOPWATCH_LAP_EN adds key_lap and a display hold.
// Ports:
//   clkin   - system clock
//   rst_n   - asynchronous active-low reset
//   tick_in - divider output; each rising edge is one centisecond
//   key_ss  - start/stop key (debounced level)
//   key_clr - clear key (debounced level)
//   key_lap - lap key (STOPWATCH_LAP_EN only)
//   gen_en  - divider enable, high in RUN
//   cs_bcd  - centiseconds, 2 BCD digits
//   sec_bcd - seconds, 2 BCD digits
//   min_bcd - minutes, 2 BCD digits
//   running - high in RUN
//   ovf     - one-cycle pulse on wrap 59:59.99 -> 00:00.00
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_HZ = 100
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       key_ss,
    input  logic       key_clr,
`ifdef STOPWATCH_LAP_EN
    input  logic       key_lap,
`endif
    output logic       gen_en,
    output logic [7:0] cs_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       running,
    output logic       ovf
);

    // TICK_HZ is informational; counting always assumes 0.01 s per tick.
    if (TICK_HZ == 0) begin : g_bad_tick_hz
        $error("stopwatch_core: TICK_HZ must be non-zero");
    end

    logic tick_q, ss_q, clr_q;
    logic tick_rise, ss_rise, clr_rise;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
            ss_q   <= 1'b0;
            clr_q  <= 1'b0;
        end else begin
            tick_q <= tick_in;
            ss_q   <= key_ss;
            clr_q  <= key_clr;
        end
    end

    assign tick_rise = tick_in & ~tick_q;
    assign ss_rise   = key_ss  & ~ss_q;
    assign clr_rise  = key_clr & ~clr_q;

    sw_state_e state_q, state_d;
    logic      run_q, ovf_q;
    logic      count_en;
    logic [5:0] cy;
    logic [3:0] cs0, cs1, s0, s1, m0, m1;

    always_comb begin
        state_d = state_q;
        if (clr_rise) begin
            state_d = ST_IDLE;
        end else if (ss_rise) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= (state_d == ST_RUN);
            ovf_q   <= cy[5];
        end
    end

    // The tick is judged against the current state, so tick+ss in RUN is
    // counted before pausing, while tick+ss in IDLE/PAUSE is not.
    assign count_en = tick_rise & ~clr_rise & (state_q == ST_RUN);

    bcd_digit #(.MAX(DIGIT_MAX_9)) u_cs0 (
        .clkin(clkin), .rst_n(rst_n), .clr(clr_rise), .inc(count_en), .q(cs0), .carry(cy[0]));
    bcd_digit #(.MAX(DIGIT_MAX_9)) u_cs1 (
        .clkin(clkin), .rst_n(rst_n), .clr(clr_rise), .inc(cy[0]),    .q(cs1), .carry(cy[1]));
    bcd_digit #(.MAX(DIGIT_MAX_9)) u_sec0 (
        .clkin(clkin), .rst_n(rst_n), .clr(clr_rise), .inc(cy[1]),    .q(s0),  .carry(cy[2]));
    bcd_digit #(.MAX(DIGIT_MAX_5)) u_sec1 (
        .clkin(clkin), .rst_n(rst_n), .clr(clr_rise), .inc(cy[2]),    .q(s1),  .carry(cy[3]));
    bcd_digit #(.MAX(DIGIT_MAX_9)) u_min0 (
        .clkin(clkin), .rst_n(rst_n), .clr(clr_rise), .inc(cy[3]),    .q(m0),  .carry(cy[4]));
    bcd_digit #(.MAX(DIGIT_MAX_5)) u_min1 (
        .clkin(clkin), .rst_n(rst_n), .clr(clr_rise), .inc(cy[4]),    .q(m1),  .carry(cy[5]));

    logic [23:0] live;
    logic [23:0] disp;

    assign live = {m1, m0, s1, s0, cs1, cs0};

`ifdef STOPWATCH_LAP_EN
    logic        lap_q, hold_q;
    logic        lap_rise;
    logic [23:0] held_q;

    assign lap_rise = key_lap & ~lap_q;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lap_q  <= 1'b0;
            hold_q <= 1'b0;
            held_q <= '0;
        end else begin
            lap_q <= key_lap;
            if (clr_rise) begin
                hold_q <= 1'b0;
            end else if (lap_rise && (state_q == ST_RUN)) begin
                hold_q <= ~hold_q;
                if (!hold_q) begin
                    held_q <= live;
                end
            end
        end
    end

    assign disp = hold_q ? held_q : live;
`else
    assign disp = live;
`endif

    assign cs_bcd  = disp[7:0];
    assign sec_bcd = disp[15:8];
    assign min_bcd = disp[23:16];
    assign gen_en  = run_q;
    assign running = run_q;
    assign ovf     = ovf_q;

endmodule
